// File: rtl/serial_alu_engine_pkg.sv
// Shared definitions for the bit-serial ALU engine and the parallel ALU.
// Holds the 4-bit op encodings, the sequencer state enum and a small
// helper that tells which ops start their carry chain at 1.
package serial_alu_engine_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // SUB and SLT both compute a + ~b + 1, so the chain is seeded with 1.
    function automatic logic is_sub_like(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/serial_alu_engine_if.sv
// Start/ready/done handshake bundle for the serial ALU engine.
//   master: drives start, op, a, b; observes ready, done and the result/flags.
//   slave : the engine side.
interface serial_alu_engine_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;

    modport master (
        output start, op, a, b,
        input  ready, done, result, zero, cout, overflow
    );

    modport slave (
        input  start, op, a, b,
        output ready, done, result, zero, cout, overflow
    );
endinterface

// File: rtl/serial_alu_engine_bit_alu.sv
// BitALU: single-bit ALU slice, purely combinational.
// Ports: a, b    operand bits
//        cin     carry in (used by ADD/SUB/SLT)
//        less    value returned for SLT (supplied by the MSB logic upstream)
//        op      4-bit op code
//        res     result bit
//        cout    carry out (0 for logic and unsupported ops)
module serial_alu_engine_bit_alu
    import serial_alu_engine_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       less,
    input  logic [3:0] op,
    output logic       res,
    output logic       cout
);
    logic b_eff;

    always_comb begin
        res   = 1'b0;
        cout  = 1'b0;
        b_eff = b;
        case (op)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOR: res = ~(a | b);
            OP_ADD: begin
                res  = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            OP_SUB, OP_SLT: begin
                b_eff = ~b;
                res   = (op == OP_SLT) ? less : (a ^ b_eff ^ cin);
                cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
            end
            default: begin
                res  = 1'b0;
                cout = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/serial_alu_engine.sv
// Bit-serial ALU sequencer. Feeds one BitALU slice one operand bit per
// clock, LSB first, owning the carry chain, bit counter, result shift
// register and the SLT sign/overflow resolution.
// Ports: clk  rising-edge clock
//        rst  synchronous active-high reset (aborts a running op)
//        bus  handshake interface (slave side): start/op/a/b in,
//             ready/done/result/zero/cout/overflow out
// Latency: accept on E0, bit i on E(i+1), done high after E(WIDTH),
// ready back after E(WIDTH+1).
module serial_alu_engine
    import serial_alu_engine_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic                clk,
    input logic                rst,
    serial_alu_engine_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;

    logic [3:0]       slice_op;
    logic             slice_res;
    logic             slice_cout;
    logic [WIDTH-1:0] shift_next;
    logic             ovf_next;
    logic [WIDTH-1:0] result_next;
    logic             cout_next;
    logic             overflow_next;

    // SLT runs the slice as a subtractor; the comparison is resolved here.
    assign slice_op = (op_reg == OP_SLT) ? OP_SUB : op_reg;

    serial_alu_engine_bit_alu u_bit_alu (
        .a    (a_reg[cnt_reg]),
        .b    (b_reg[cnt_reg]),
        .cin  (carry_reg),
        .less (1'b0),
        .op   (slice_op),
        .res  (slice_res),
        .cout (slice_cout)
    );

    always_comb begin
        shift_next    = {slice_res, shift_reg[WIDTH-1:1]};
        // On the MSB cycle carry_reg is the carry into the MSB.
        ovf_next      = carry_reg ^ slice_cout;
        result_next   = shift_next;
        cout_next     = 1'b0;
        overflow_next = 1'b0;
        case (op_reg)
            OP_SLT: begin
                // True sign of a-b is the raw difference sign corrected by overflow.
                result_next   = {{(WIDTH-1){1'b0}}, slice_res ^ ovf_next};
                cout_next     = slice_cout;
                overflow_next = 1'b0;
            end
            OP_ADD, OP_SUB: begin
                cout_next     = slice_cout;
                overflow_next = ovf_next;
            end
            default: begin
                cout_next     = 1'b0;
                overflow_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            op_reg       <= OP_AND;
            a_reg        <= '0;
            b_reg        <= '0;
            shift_reg    <= '0;
            cnt_reg      <= '0;
            carry_reg    <= 1'b0;
            bus.ready    <= 1'b1;
            bus.done     <= 1'b0;
            bus.result   <= '0;
            bus.zero     <= 1'b0;
            bus.cout     <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        op_reg    <= bus.op;
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        carry_reg <= is_sub_like(bus.op);
                        cnt_reg   <= '0;
                        shift_reg <= '0;
                        bus.ready <= 1'b0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    shift_reg <= shift_next;
                    carry_reg <= slice_cout;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BIT) begin
                        bus.result   <= result_next;
                        bus.zero     <= (result_next == '0);
                        bus.cout     <= cout_next;
                        bus.overflow <= overflow_next;
                        bus.done     <= 1'b1;
                        state_reg    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bus.done  <= 1'b0;
                    bus.ready <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    bus.ready <= 1'b1;
                    bus.done  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_alu_engine.sv
// Self-checking bench for serial_alu_engine at WIDTH=8: a table of
// directed vectors plus hand sequences for abort, ignored start and
// back-to-back operation.
module tb_serial_alu_engine;
    import serial_alu_engine_pkg::*;

    localparam int W = 8;
    // Edges from the accepting edge to the edge after which done is seen high.
    localparam int LAT = W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    serial_alu_engine_if #(.WIDTH(W)) bus ();

    serial_alu_engine #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zero;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Issue one op and wait (bounded) for done; lat = -1 if done never came.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] r, output logic z, output logic c,
                          output logic v, output int lat);
        int guard;
        guard = 0;
        while (!bus.ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        r = bus.result;
        z = bus.zero;
        c = bus.cout;
        v = bus.overflow;
    endtask

    task automatic count_done(input int n, output int pulses);
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
        end
    endtask

    initial begin
        logic [W-1:0] r;
        logic z, c, v;
        int lat, pulses, c1, c2, guard;

        //          op      a      b      res    z     c     ovf
        vecs[0]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{OP_SLT, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{OP_SLT, 8'h01, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{OP_SLT, 8'h7F, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{OP_OR,  8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{OP_XOR, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_NOR, 8'hF0, 8'h3C, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'b0011, 8'hF0, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1};

        bus.start = 1'b0;
        bus.op    = OP_AND;
        bus.a     = '0;
        bus.b     = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_ready", int'(bus.ready), 1);
        check("reset_done", int'(bus.done), 0);
        check("reset_result", int'(bus.result), 0);
        check("reset_zero", int'(bus.zero), 0);
        check("reset_cout", int'(bus.cout), 0);
        check("reset_ovf", int'(bus.overflow), 0);
        $display("txn reset ready=%0d done=%0d result=0x%02h", bus.ready, bus.done, bus.result);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, c, v, lat);
            $display("txn %0d op=%04b a=0x%02h b=0x%02h -> result=0x%02h zero=%0d cout=%0d ovf=%0d lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, r, z, c, v, lat);
            check($sformatf("vec%0d_latency", i), lat, LAT);
            check($sformatf("vec%0d_result", i), int'(r), int'(vecs[i].res));
            check($sformatf("vec%0d_zero", i), int'(z), int'(vecs[i].zero));
            check($sformatf("vec%0d_cout", i), int'(c), int'(vecs[i].cout));
            check($sformatf("vec%0d_ovf", i), int'(v), int'(vecs[i].ovf));
        end

        // start pulsed mid-RUN with different operands must be ignored.
        // Previous result (last table entry) is 0x7F and must hold during RUN.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = OP_ADD; bus.a = 8'h10; bus.b = 8'h20;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("run_ready_low", int'(bus.ready), 0);
        check("run_result_hold", int'(bus.result), 8'h7F);
        bus.start = 1'b1; bus.op = OP_OR; bus.a = 8'h55; bus.b = 8'h55;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int k = 4; k <= 30; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        $display("txn ignore_start result=0x%02h lat=%0d", bus.result, lat);
        check("ignore_latency", lat, LAT);
        check("ignore_result", int'(bus.result), 8'h30);
        count_done(12, pulses);
        check("ignore_no_extra_done", pulses, 0);

        // Back-to-back with start held high.
        bus.start = 1'b1; bus.op = OP_ADD; bus.a = 8'h01; bus.b = 8'h02;
        c1 = -1; c2 = -1; guard = 0;
        while (c1 < 0 && guard < 30) begin
            @(posedge clk); #1; guard++;
            if (bus.done) c1 = cyc;
        end
        guard = 0;
        while (c2 < 0 && guard < 30) begin
            @(posedge clk); #1; guard++;
            if (bus.done) c2 = cyc;
        end
        bus.start = 1'b0;
        $display("txn back_to_back done1=%0d done2=%0d result=0x%02h", c1, c2, bus.result);
        check("b2b_first_seen", int'(c1 >= 0), 1);
        check("b2b_spacing", c2 - c1, W + 2);
        check("b2b_result", int'(bus.result), 8'h03);

        // Reset asserted on cycle 3 of a RUN aborts it.
        run_op(OP_ADD, 8'h20, 8'h22, r, z, c, v, lat);
        check("pre_abort_result", int'(r), 8'h42);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = OP_OR; bus.a = 8'h0F; bus.b = 8'hF0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("txn abort ready=%0d done=%0d result=0x%02h", bus.ready, bus.done, bus.result);
        check("abort_ready", int'(bus.ready), 1);
        check("abort_done", int'(bus.done), 0);
        check("abort_result", int'(bus.result), 0);
        count_done(12, pulses);
        check("abort_no_done", pulses, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
